// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_pkg
// Description : Shared types and constants for the SPI command controller:
//               the transaction state encoding, the position of the
//               read/write flag in the command byte, and the default byte
//               returned on a read-data underrun.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

    // Transaction state, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    // Command byte bit selecting read (1) or write (0)
    localparam int CMD_RW_BIT = 7;

    // Byte placed on MISO when prefetched read data is not ready yet
    localparam logic [7:0] DEF_UNDERRUN_BYTE = 8'hEE;

endpackage : spi_cmd_pkg
`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_ctrl
// Description : Frame-level transaction controller between the byte-level
//               SPI slave engine and the internal register bus. The first
//               byte of each frame is a command (bit 7 = read, low bits =
//               start address); following bytes are register writes, or
//               MISO slots served from a one-entry read prefetch buffer,
//               with optional address auto-increment.
// Ports       : clk, rst_n            - clock, async active-low reset
//               frame_start/frame_end - SSEL assert / deassert pulses
//               rx_valid, rx_byte     - received MOSI byte
//               tx_req                - engine asks for next MISO byte
//               tx_byte, tx_load      - MISO byte and its load strobe
//               reg_addr/wdata/we/re  - register bus request side
//               reg_rdata, reg_rvalid - register bus read response
//               busy                  - state is not IDLE
//               err_underrun          - sticky underrun flag per frame
//               frame_count           - frames started, modulo 256
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int         ADDR_W        = 7,
    parameter bit         AUTO_INC      = 1'b1,
    parameter logic [7:0] UNDERRUN_BYTE = DEF_UNDERRUN_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              tx_req,
    output logic [7:0]        tx_byte,
    output logic              tx_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_rvalid,
    output logic              busy,
    output logic              err_underrun,
    output logic [7:0]        frame_count
);

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_wdata;
    logic                r_we;
    logic                r_re;
    logic [7:0]          r_tx_byte;
    logic                r_tx_load;
    logic                r_err_underrun;
    logic [7:0]          r_frame_count;
    logic [7:0]          r_buf;
    logic                r_buf_valid;
    logic                r_rd_pending;

    // A response only counts when we actually have a read in flight
    logic                w_rd_ret;
    assign w_rd_ret = reg_rvalid && r_rd_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_wdata        <= 8'h00;
            r_we           <= 1'b0;
            r_re           <= 1'b0;
            r_tx_byte      <= 8'h00;
            r_tx_load      <= 1'b0;
            r_err_underrun <= 1'b0;
            r_frame_count  <= 8'h00;
            r_buf          <= 8'h00;
            r_buf_valid    <= 1'b0;
            r_rd_pending   <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            // Every tx_req gets exactly one load pulse on the next cycle
            r_tx_load <= tx_req;
            if (tx_req) begin
                r_tx_byte <= 8'h00;
            end

            // Write address advances the cycle after its strobe
            if (r_we && AUTO_INC) begin
                r_addr <= r_addr + c_addr_one;
            end

            // Responses arriving outside READ belong to an abandoned frame
            if (reg_rvalid && (frame_start || r_state != READ)) begin
                r_rd_pending <= 1'b0;
            end

            if (frame_start) begin
                // Restart from any state; a lost frame_end is tolerated
                r_state        <= CMD;
                r_frame_count  <= r_frame_count + 8'd1;
                r_err_underrun <= 1'b0;
                r_buf_valid    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                    end

                    CMD: begin
                        if (tx_req) begin
                            r_tx_byte <= r_frame_count;
                        end
                        if (frame_end) begin
                            r_state <= IDLE;
                        end else if (rx_valid) begin
                            r_addr <= rx_byte[ADDR_W-1:0];
                            if (rx_byte[CMD_RW_BIT]) begin
                                // First prefetch goes out immediately
                                r_state      <= READ;
                                r_re         <= 1'b1;
                                r_rd_pending <= 1'b1;
                            end else begin
                                r_state <= WRITE;
                            end
                        end
                    end

                    WRITE: begin
                        // A byte completing together with frame_end is
                        // still written
                        if (rx_valid) begin
                            r_we    <= 1'b1;
                            r_wdata <= rx_byte;
                        end
                        if (frame_end) begin
                            r_state <= IDLE;
                        end
                    end

                    READ: begin
                        if (tx_req) begin
                            if (r_buf_valid) begin
                                r_tx_byte    <= r_buf;
                                r_buf_valid  <= 1'b0;
                                r_re         <= 1'b1;
                                r_rd_pending <= 1'b1;
                            end else if (w_rd_ret) begin
                                // Data arrives just in time: bypass the
                                // buffer, keep one read in flight
                                r_tx_byte <= reg_rdata;
                                r_re      <= 1'b1;
                                if (AUTO_INC) begin
                                    r_addr <= r_addr + c_addr_one;
                                end
                            end else begin
                                // Read stays pending; its data serves the
                                // next slot
                                r_tx_byte      <= UNDERRUN_BYTE;
                                r_err_underrun <= 1'b1;
                            end
                        end else if (w_rd_ret) begin
                            r_buf        <= reg_rdata;
                            r_buf_valid  <= 1'b1;
                            r_rd_pending <= 1'b0;
                            if (AUTO_INC) begin
                                r_addr <= r_addr + c_addr_one;
                            end
                        end
                        if (frame_end) begin
                            r_state     <= IDLE;
                            r_buf_valid <= 1'b0;
                        end
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_byte      = r_tx_byte;
    assign tx_load      = r_tx_load;
    assign reg_addr     = r_addr;
    assign reg_wdata    = r_wdata;
    assign reg_we       = r_we;
    assign reg_re       = r_re;
    assign busy         = (r_state != IDLE);
    assign err_underrun = r_err_underrun;
    assign frame_count  = r_frame_count;

endmodule : spi_cmd_ctrl
`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_ctrl
// Description : Directed self-checking bench for spi_cmd_ctrl. A small
//               register responder returns 8'h40 + address after a
//               programmable latency; monitors log writes, reads and MISO
//               bytes, which are compared against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_ctrl;

    localparam int c_addr_w = 7;

    logic                clk;
    logic                rst_n;
    logic                frame_start;
    logic                frame_end;
    logic                rx_valid;
    logic [7:0]          rx_byte;
    logic                tx_req;
    logic [7:0]          tx_byte;
    logic                tx_load;
    logic [c_addr_w-1:0] reg_addr;
    logic [7:0]          reg_wdata;
    logic                reg_we;
    logic                reg_re;
    logic [7:0]          reg_rdata;
    logic                reg_rvalid;
    logic                busy;
    logic                err_underrun;
    logic [7:0]          frame_count;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 2;

    logic [7:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] ra_q[$];
    logic [7:0] tx_q[$];

    spi_cmd_ctrl #(
        .ADDR_W        (c_addr_w),
        .AUTO_INC      (1'b1),
        .UNDERRUN_BYTE (8'hEE)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .tx_req       (tx_req),
        .tx_byte      (tx_byte),
        .tx_load      (tx_load),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .reg_rvalid   (reg_rvalid),
        .busy         (busy),
        .err_underrun (err_underrun),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sample mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (reg_we) begin
            wa_q.push_back({1'b0, reg_addr});
            wd_q.push_back(reg_wdata);
        end
        if (reg_re) ra_q.push_back({1'b0, reg_addr});
        if (tx_load) tx_q.push_back(tx_byte);
    end

    // Register responder: one read at a time, data = 8'h40 + address
    initial begin
        logic [7:0] a;
        reg_rvalid = 1'b0;
        reg_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (reg_re === 1'b1) begin
                a = {1'b0, reg_addr};
                repeat (lat) @(posedge clk);
                #1;
                reg_rdata  = 8'h40 + a;
                reg_rvalid = 1'b1;
                @(posedge clk);
                #1;
                reg_rvalid = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [7:0] q[$], input int i);
        if (i < q.size()) return {24'h0, q[i]};
        return 32'hxxxxxxxx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic fs();
        frame_start = 1'b1; step(); frame_start = 1'b0;
    endtask

    task automatic fe();
        frame_end = 1'b1; step(); frame_end = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_valid = 1'b1; rx_byte = b; step(); rx_valid = 1'b0;
    endtask

    task automatic txr();
        tx_req = 1'b1; step(); tx_req = 1'b0;
    endtask

    task automatic clear_q();
        wa_q.delete(); wd_q.delete(); ra_q.delete(); tx_q.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        rx_valid    = 1'b0;
        rx_byte     = 8'h00;
        tx_req      = 1'b0;
        idle(3);

        // ---- Reset state ----
        check("rst_outputs", {tx_byte, tx_load, 1'b0, reg_addr, reg_wdata},
              32'h0);
        check("rst_strobes", {busy, err_underrun, reg_we, reg_re}, 32'h0);
        check("rst_fcount", frame_count, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // ---- Write frame: cmd 05, data AA, 55 ----
        clear_q();
        fs(); idle(1);
        check("wr_busy", busy, 32'h1);
        txr(); idle(7); rx(8'h05);
        txr(); idle(7); rx(8'hAA);
        txr(); idle(7); rx(8'h55);
        idle(2); fe(); idle(3);
        check("wr_count", wa_q.size(), 32'd2);
        check("wr0_addr", qat(wa_q, 0), 32'h05);
        check("wr0_data", qat(wd_q, 0), 32'hAA);
        check("wr1_addr", qat(wa_q, 1), 32'h06);
        check("wr1_data", qat(wd_q, 1), 32'h55);
        check("wr_tx0", qat(tx_q, 0), 32'h01);
        check("wr_tx1", qat(tx_q, 1), 32'h00);
        check("wr_tx2", qat(tx_q, 2), 32'h00);
        check("wr_txn", tx_q.size(), 32'd3);
        check("wr_idle", busy, 32'h0);

        // ---- Read frame: cmd 83, latency 2, slots 16 cycles apart ----
        clear_q();
        lat = 2;
        fs(); idle(1);
        txr(); idle(7); rx(8'h83);
        idle(15); txr();
        idle(15); txr();
        idle(5); fe(); idle(5);
        check("rd_nre", ra_q.size(), 32'd3);
        check("rd_re0", qat(ra_q, 0), 32'h03);
        check("rd_re1", qat(ra_q, 1), 32'h04);
        check("rd_re2", qat(ra_q, 2), 32'h05);
        check("rd_tx0", qat(tx_q, 0), 32'h02);
        check("rd_tx1", qat(tx_q, 1), 32'h43);
        check("rd_tx2", qat(tx_q, 2), 32'h44);
        check("rd_err", err_underrun, 32'h0);

        // ---- Underrun: latency 40, slot 10 cycles after cmd ----
        clear_q();
        lat = 40;
        fs(); idle(1);
        txr(); idle(7); rx(8'h81);
        idle(9); txr();
        check("ur_err_set", err_underrun, 32'h1);
        idle(40); txr();
        // Abandon the frame with the next read still in flight
        fe(); idle(50);
        check("ur_tx0", qat(tx_q, 0), 32'h03);
        check("ur_tx1", qat(tx_q, 1), 32'hEE);
        check("ur_tx2", qat(tx_q, 2), 32'h41);
        check("ur_re1", qat(ra_q, 1), 32'h02);
        check("ur_idle", busy, 32'h0);
        check("ur_addr_hold", reg_addr, 32'h02);
        check("ur_err_sticky", err_underrun, 32'h1);

        // ---- Fresh read frame, rvalid coincides with tx_req ----
        clear_q();
        lat = 3;
        fs();
        check("fw_err_clr", err_underrun, 32'h0);
        check("fw_fcount", frame_count, 32'h04);
        idle(1);
        txr(); idle(7); rx(8'h8A);
        idle(3); txr();
        idle(10); txr();
        idle(5); fe(); idle(5);
        check("fw_tx0", qat(tx_q, 0), 32'h04);
        check("fw_tx1", qat(tx_q, 1), 32'h4A);
        check("fw_tx2", qat(tx_q, 2), 32'h4B);
        check("fw_err", err_underrun, 32'h0);
        check("fw_re1", qat(ra_q, 1), 32'h0B);
        check("fw_re2", qat(ra_q, 2), 32'h0C);

        // ---- Address wrap, last byte together with frame_end ----
        clear_q();
        fs(); idle(1);
        txr(); idle(7); rx(8'h7F);
        txr(); idle(7); rx(8'h11);
        idle(8);
        rx_valid = 1'b1; rx_byte = 8'h22; frame_end = 1'b1;
        step();
        rx_valid = 1'b0; frame_end = 1'b0;
        idle(3);
        check("wrap_n", wa_q.size(), 32'd2);
        check("wrap_a0", qat(wa_q, 0), 32'h7F);
        check("wrap_a1", qat(wa_q, 1), 32'h00);
        check("wrap_d1", qat(wd_q, 1), 32'h22);
        check("wrap_tx0", qat(tx_q, 0), 32'h05);
        check("wrap_idle", busy, 32'h0);

        // ---- Reset between rx_valid and the write strobe ----
        clear_q();
        fs(); idle(1);
        rx(8'h10);
        rx_valid = 1'b1; rx_byte = 8'h99;
        #2 rst_n = 1'b0;
        step();
        rx_valid = 1'b0;
        check("ar_outputs", {tx_byte, tx_load, 1'b0, reg_addr, reg_wdata},
              32'h0);
        check("ar_flags", {busy, err_underrun, reg_we, reg_re}, 32'h0);
        check("ar_fcount", frame_count, 32'h0);
        idle(2);
        check("ar_no_we", wa_q.size(), 32'd0);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_cmd_ctrl
`default_nettype wire

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Transaction controller that sits between the byte-level SPI slave engine and an internal register bus. It decodes a command byte per frame and sequences register writes, or prefetched register reads, with auto-incrementing addresses. It also supplies every MISO byte to the engine: a status byte, then read data, or a fixed underrun byte when data is late.

Parameters:
ADDR_W, 7, register address width; equals the command byte address field width.
AUTO_INC, 1, 1 = address increments after each data byte; 0 = address stays fixed.
UNDERRUN_BYTE, 8'hEE, byte sent when read data is not ready at tx_req.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
frame_start  in  1  one-cycle pulse at SSEL assertion.
frame_end  in  1  one-cycle pulse at SSEL deassertion.
rx_valid  in  1  one-cycle pulse: complete byte received.
rx_byte  in  8  received byte; valid with rx_valid.
tx_req  in  1  one-cycle pulse: engine needs the next MISO byte.
tx_byte  out  8  byte to load into the engine shift register.
tx_load  out  1  one-cycle pulse: tx_byte valid.
reg_addr  out  ADDR_W  register bus address.
reg_wdata  out  8  register write data.
reg_we  out  1  one-cycle write strobe.
reg_re  out  1  one-cycle read strobe.
reg_rdata  in  8  read data; valid with reg_rvalid.
reg_rvalid  in  1  read response pulse, 1 or more cycles after reg_re.
busy  out  1  high while the state is not IDLE.
err_underrun  out  1  sticky; set on underrun, cleared by frame_start.
frame_count  out  8  frames started, modulo 256.

Behaviour:
- Reset: state=IDLE; all outputs 0; prefetch buffer invalid; no read outstanding.
- States:
  - IDLE: frame_start -> CMD.
  - CMD: rx_valid -> WRITE if rx_byte[7]=0, READ if rx_byte[7]=1. reg_addr <= rx_byte[ADDR_W-1:0].
  - WRITE/READ: frame_end -> IDLE from any non-IDLE state.
- frame_start in any state: frame_count+1 (wraps 255->0), err_underrun cleared, state -> CMD. A missing frame_end is tolerated.
- Command byte: tx_req while in CMD (first byte of the frame) -> tx_byte = frame_count (value after the increment).
- WRITE:
  - Each rx_valid -> next cycle: reg_we=1, reg_wdata=rx_byte, reg_addr=current address.
  - Address increments in the cycle after reg_we when AUTO_INC=1.
  - tx_req in WRITE -> tx_byte=8'h00.
- READ:
  - Entering READ issues reg_re one cycle after the command byte's rx_valid.
  - At most one read outstanding.
  - reg_rvalid -> buffer <= reg_rdata, buffer valid, address increments (AUTO_INC=1).
  - tx_req with buffer valid -> tx_byte=buffer, buffer invalid, next reg_re issued the following cycle.
  - tx_req with buffer empty -> tx_byte=UNDERRUN_BYTE, err_underrun=1. The outstanding read stays pending; its data serves the next tx_req.
  - rx_valid in READ is ignored (MOSI is don't-care).
- tx_load: exactly one pulse per tx_req, asserted 1 cycle after tx_req, with tx_byte stable in that cycle.
- Address wrap: 2^ADDR_W-1 -> 0, silently.
- Simultaneous rx_valid and frame_end in WRITE: the write is still issued, then IDLE.
- Simultaneous tx_req and reg_rvalid with buffer empty: forward reg_rdata directly to tx_byte, with no underrun.
- frame_end with a read outstanding: the returning reg_rvalid is discarded in IDLE and the buffer is invalidated. Integration constraint: read latency must be shorter than the minimum inter-frame gap.
- reg_rvalid with no read outstanding: ignored.
- Asynchronous reset mid-frame: immediate return to reset state; no strobes are issued.

Decomposition:
- Package spi_cmd_pkg holds:
  - state enum: IDLE, CMD, WRITE, READ;
  - CMD_RW_BIT=7;
  - default UNDERRUN_BYTE.
- No sub-module inside; the prefetch buffer is a small register plus flag.
- Top level instantiates spi_cmd_ctrl beside the existing byte-level slave engine.

Test Plan:
- Reset, then frame with cmd 8'h05 and data 8'hAA, 8'h55 -> reg_we at addr 5 with data AA, then addr 6 with 55. tx bytes: frame_count=1, then 00, 00.
- Read frame, cmd 8'h83, responder latency 2, tx_req spaced 16 cycles -> reg_re at 3, 4, 5; MISO bytes: frame_count, then rdata[3], rdata[4].
- Read frame with responder latency 40 and tx_req 10 cycles after the cmd byte -> tx_byte=8'hEE, err_underrun=1. The next frame_start clears it.
- Write starting at addr 7'h7F with 2 data bytes -> writes at 7F, then 00.
- frame_end mid-read with rvalid arriving afterwards -> state IDLE, no buffer load. The next read frame returns fresh data.
- rst_n low during WRITE between rx_valid and reg_we -> no reg_we; all outputs 0; frame_count=0.
